// File: rtl/fetch_issue_queue_pkg.sv
// Shared types for the fetch/decode boundary: width constants and the
// fetch-entry struct carried from the fetch unit through the issue queue.
`timescale 1ns/1ps
package fetch_issue_queue_pkg;

  localparam int addressWidth            = 64;
  localparam int instructionWidth        = 32;
  localparam int PidSize                 = 20;
  localparam int TidSize                 = 16;
  localparam int instructionCounterWidth = 64;

  typedef struct packed {
    logic [instructionWidth-1:0] instruction;
    logic [addressWidth-1:0]     address;
    logic [PidSize-1:0]          pid;
    logic [TidSize-1:0]          tid;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_issue_queue_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with push/pop, full/empty
// and a synchronous flush. The head entry is presented combinationally.
`timescale 1ns/1ps
module fetch_fifo
  import fetch_issue_queue_pkg::*;
#(
  parameter int depth = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int ptr_w   = $clog2(depth);
  localparam int count_w = ptr_w + 1;

  fetch_entry_t       mem [depth];
  logic [ptr_w-1:0]   wr_ptr;
  logic [ptr_w-1:0]   rd_ptr;
  logic [count_w-1:0] count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == count_w'(depth));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at depth.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: state updates use <= so every register samples pre-edge values,
      // independent of statement order inside the block.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + count_w'(do_push) - count_w'(do_pop);
    end
  end

  // Entry storage write.
  // NOTE: storage has no reset; an entry is only read after it was written,
  // and leaving it out keeps the array mappable onto plain RAM/flops.
  always_ff @(posedge clock_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_issue_queue.sv
// fetch_issue_queue: buffers fetched instructions and issues them in order,
// one per cycle, tagging each with a unique 64-bit major ID.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let an instruction that
// arrives at an empty, unstalled queue go straight to the output registers.
`timescale 1ns/1ps
module fetch_issue_queue
  import fetch_issue_queue_pkg::*;
#(
  parameter int queueDepth = 8
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               fetchValid_i,
  output logic                               fetchReady_o,
  input  logic [instructionWidth-1:0]        fetchInstruction_i,
  input  logic [addressWidth-1:0]            fetchAddress_i,
  input  logic [PidSize-1:0]                 fetchPid_i,
  input  logic [TidSize-1:0]                 fetchTid_i,
  input  logic                               flush_i,
  input  logic                               stall_i,
  output logic                               enable_o,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic [PidSize-1:0]                 instructionPid_o,
  output logic [TidSize-1:0]                 instructionTid_o,
  output logic [instructionCounterWidth-1:0] instructionMajId_o
);

  fetch_entry_t                       fetch_entry;
  fetch_entry_t                       fifo_head;
  fetch_entry_t                       out_entry;
  logic                               fifo_full;
  logic                               fifo_empty;
  logic                               push;
  logic                               bypass;
  logic                               fifo_push;
  logic                               fifo_pop;
  logic [instructionCounterWidth-1:0] maj_counter;

  assign fetch_entry = '{instruction: fetchInstruction_i, address: fetchAddress_i,
                         pid: fetchPid_i, tid: fetchTid_i};

  assign fetchReady_o = !fifo_full;
  assign push         = fetchValid_i && fetchReady_o && !flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue with a free decoder lets the arriving entry skip the FIFO.
  assign bypass = push && fifo_empty && !stall_i;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = push && !bypass;
  assign fifo_pop  = !stall_i && !flush_i && !fifo_empty;

  fetch_fifo #(.depth(queueDepth)) u_fifo (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .flush     (flush_i),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data (fetch_entry),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Issue register and major-ID counter; stall freezes both, flush only
  // drops the valid so IDs keep counting across a flush.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      out_entry          <= '0;
      enable_o           <= 1'b0;
      instructionMajId_o <= '0;
      maj_counter        <= '0;
    end else if (flush_i) begin
      enable_o <= 1'b0;
    end else if (!stall_i) begin
      if (bypass || !fifo_empty) begin
        out_entry          <= bypass ? fetch_entry : fifo_head;
        enable_o           <= 1'b1;
        instructionMajId_o <= maj_counter;
        maj_counter        <= maj_counter + 1'b1;
      end else begin
        enable_o <= 1'b0;
      end
    end
  end

  assign instruction_o        = out_entry.instruction;
  assign instructionAddress_o = out_entry.address;
  assign instructionPid_o     = out_entry.pid;
  assign instructionTid_o     = out_entry.tid;

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Directed self-checking bench for fetch_issue_queue (queueDepth = 8).
// Expected issue latency follows FETCH_QUEUE_BYPASS_EN when it is defined.
`timescale 1ns/1ps
module tb_fetch_issue_queue;
  import fetch_issue_queue_pkg::*;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic                               clock_i = 1'b0;
  logic                               reset_i;
  logic                               fetchValid_i;
  logic                               fetchReady_o;
  logic [instructionWidth-1:0]        fetchInstruction_i;
  logic [addressWidth-1:0]            fetchAddress_i;
  logic [PidSize-1:0]                 fetchPid_i;
  logic [TidSize-1:0]                 fetchTid_i;
  logic                               flush_i;
  logic                               stall_i;
  logic                               enable_o;
  logic [instructionWidth-1:0]        instruction_o;
  logic [addressWidth-1:0]            instructionAddress_o;
  logic [PidSize-1:0]                 instructionPid_o;
  logic [TidSize-1:0]                 instructionTid_o;
  logic [instructionCounterWidth-1:0] instructionMajId_o;

  int checks   = 0;
  int failures = 0;

  fetch_issue_queue #(.queueDepth(8)) dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .fetchValid_i         (fetchValid_i),
    .fetchReady_o         (fetchReady_o),
    .fetchInstruction_i   (fetchInstruction_i),
    .fetchAddress_i       (fetchAddress_i),
    .fetchPid_i           (fetchPid_i),
    .fetchTid_i           (fetchTid_i),
    .flush_i              (flush_i),
    .stall_i              (stall_i),
    .enable_o             (enable_o),
    .instruction_o        (instruction_o),
    .instructionAddress_o (instructionAddress_o),
    .instructionPid_o     (instructionPid_o),
    .instructionTid_o     (instructionTid_o),
    .instructionMajId_o   (instructionMajId_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [7:0] tag, input int i);
    fetch_entry_t e;
    e.instruction = {tag, 16'h0013, 8'(i)};
    e.address     = {32'h8000_0000, 8'h00, tag, 8'h00, 8'(i * 4)};
    e.pid         = {4'h0, tag, 8'(i)};
    e.tid         = {tag, 8'(i + 1)};
    return e;
  endfunction

  task automatic drive(input logic valid, input fetch_entry_t e);
    fetchValid_i       = valid;
    fetchInstruction_i = e.instruction;
    fetchAddress_i     = e.address;
    fetchPid_i         = e.pid;
    fetchTid_i         = e.tid;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check_out(input string tag, input logic en, input fetch_entry_t e,
                           input logic [63:0] id);
    check({tag, ".enable"}, 64'(enable_o), 64'(en));
    if (en) begin
      check({tag, ".instr"}, 64'(instruction_o), 64'(e.instruction));
      check({tag, ".addr"}, instructionAddress_o, e.address);
      check({tag, ".pid_tid"}, 64'({instructionPid_o, instructionTid_o}), 64'({e.pid, e.tid}));
      check({tag, ".majid"}, instructionMajId_o, id);
    end
  endtask

  // One push into an empty, unstalled queue; it must issue after LAT edges.
  task automatic run_single(input string tag, input fetch_entry_t e, input logic [63:0] id);
    drive(1'b1, e);
    for (int k = 1; k <= 3; k++) begin
      step();
      drive(1'b0, '0);
      if (k == LAT) check_out(tag, 1'b1, e, id);
      else          check({tag, ".idle"}, 64'(enable_o), 64'd0);
    end
  endtask

  logic [63:0] exp_id;

  initial begin
    reset_i = 1'b1;
    flush_i = 1'b0;
    stall_i = 1'b0;
    drive(1'b0, '0);
    exp_id  = 0;

    // Reset state.
    repeat (2) step();
    check("rst.enable", 64'(enable_o), 64'd0);
    check("rst.ready", 64'(fetchReady_o), 64'd1);
    check("rst.instr", 64'(instruction_o), 64'd0);
    check("rst.addr", instructionAddress_o, 64'd0);
    check("rst.majid", instructionMajId_o, 64'd0);
    reset_i = 1'b0;
    step();

    // Three back-to-back pushes issue on consecutive cycles, IDs 0..2.
    for (int k = 1; k <= 5; k++) begin
      if (k <= 3) drive(1'b1, mk(8'hA0, k - 1));
      else        drive(1'b0, '0);
      step();
      if (k - LAT >= 0 && k - LAT <= 2)
        check_out("burst", 1'b1, mk(8'hA0, k - LAT), exp_id + 64'(k - LAT));
      else
        check("burst.idle", 64'(enable_o), 64'd0);
    end
    drive(1'b0, '0);
    exp_id = 3;

    // Stalled: fill to full, ninth push refused, outputs frozen.
    stall_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("fill.ready_pre", 64'(fetchReady_o), 64'(i < 8));
      drive(1'b1, mk(8'hB0, i));
      step();
      check("fill.ready_post", 64'(fetchReady_o), 64'(i < 7));
      check("fill.frozen_en", 64'(enable_o), 64'd0);
      check("fill.frozen_id", instructionMajId_o, 64'd2);
      check("fill.frozen_instr", 64'(instruction_o), 64'(mk(8'hA0, 2).instruction));
    end
    drive(1'b0, '0);
    stall_i = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step();
      check_out("drain", 1'b1, mk(8'hB0, j), exp_id + 64'(j));
      check("drain.ready", 64'(fetchReady_o), 64'd1);
    end
    step();
    check("drain.ninth_dropped", 64'(enable_o), 64'd0);
    exp_id = exp_id + 8;

    // Stall raised while an issue is valid: hold for 3 cycles.
    stall_i = 1'b1;
    drive(1'b1, mk(8'hC0, 0));
    step();
    drive(1'b1, mk(8'hC0, 1));
    step();
    drive(1'b0, '0);
    stall_i = 1'b0;
    step();
    check_out("hold.first", 1'b1, mk(8'hC0, 0), exp_id);
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_out("hold.stalled", 1'b1, mk(8'hC0, 0), exp_id);
    end
    stall_i = 1'b0;
    step();
    check_out("hold.next", 1'b1, mk(8'hC0, 1), exp_id + 1);
    step();
    check("hold.idle", 64'(enable_o), 64'd0);
    exp_id = exp_id + 2;

    // Flush with four entries queued, stalled valid output and a push.
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mk(8'hD0, i));
      step();
    end
    drive(1'b0, '0);
    stall_i = 1'b0;
    step();
    check_out("flush.pre", 1'b1, mk(8'hD0, 0), exp_id);
    exp_id = exp_id + 1;
    stall_i = 1'b1;
    flush_i = 1'b1;
    drive(1'b1, mk(8'hD0, 9));
    step();
    check("flush.enable", 64'(enable_o), 64'd0);
    check("flush.ready", 64'(fetchReady_o), 64'd1);
    flush_i = 1'b0;
    stall_i = 1'b0;
    drive(1'b0, '0);
    step();
    check("flush.empty", 64'(enable_o), 64'd0);
    run_single("flush.after", mk(8'hE0, 0), exp_id);
    exp_id = exp_id + 1;

    // Major-ID wrap at 2^64.
    stall_i = 1'b1;
    drive(1'b1, mk(8'hF0, 0));
    step();
    drive(1'b1, mk(8'hF0, 1));
    step();
    drive(1'b0, '0);
    force dut.maj_counter = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.maj_counter;
    stall_i = 1'b0;
    step();
    check_out("wrap.max", 1'b1, mk(8'hF0, 0), 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check_out("wrap.zero", 1'b1, mk(8'hF0, 1), 64'd0);
    step();

    // Asynchronous reset mid-stream, between clock edges.
    stall_i = 1'b1;
    drive(1'b1, mk(8'h50, 0));
    step();
    drive(1'b1, mk(8'h50, 1));
    step();
    drive(1'b0, '0);
    stall_i = 1'b0;
    step();
    check("areset.pre_enable", 64'(enable_o), 64'd1);
    #2;
    reset_i = 1'b1;
    #1;
    check("areset.enable", 64'(enable_o), 64'd0);
    check("areset.instr", 64'(instruction_o), 64'd0);
    check("areset.majid", instructionMajId_o, 64'd0);
    check("areset.ready", 64'(fetchReady_o), 64'd1);
    #1;
    reset_i = 1'b0;
    step();
    check("areset.queue_empty", 64'(enable_o), 64'd0);
    run_single("areset.first", mk(8'h60, 0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
